// File: rtl/ua_receiver.sv
// ua_receiver: oversampled UART receive stage.
// The line is synchronised first. A start bit is validated at its centre,
// then 8 data bits are shifted in LSB first and the stop bit is checked.
// A good byte is presented on dout_byte with a one-clock dout_rdy strobe.
// A low stop bit gives a one-clock frame_err strobe, and the FSM then waits
// in BREAK until the line returns high.
module ua_receiver #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ser_in,
  output logic [7:0] dout_byte,
  output logic       dout_rdy,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);

  // Tick counts at which the start bit (half period) and each later bit
  // (full period) are sampled, measured from the previous decision point.
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          sync1;
  logic          rx;
  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  // Two-flop synchroniser; both flops reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= ser_in;
      rx    <= sync1;
    end
  end

  // Receive FSM, counters, shift register and output strobes.
  // The strobes default low every clock, so each one lasts exactly one clk
  // even when enable is held high for several clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dout_byte <= '0;
      dout_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dout_rdy  <= 1'b0;
      frame_err <= 1'b0;
      if (enable) begin
        case (state)
          S_IDLE: begin
            if (!rx) begin
              state    <= S_START;
              tick_cnt <= '0;
            end
          end

          S_START: begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              if (!rx) begin
                state   <= S_DATA;
                bit_cnt <= '0;
              end else begin
                // Line went high again before the bit centre: false start.
                state <= S_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          S_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx, shreg[7:1]};
              if (bit_cnt == 3'd7) begin
                state <= S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          S_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (rx) begin
                dout_byte <= shreg;
                dout_rdy  <= 1'b1;
                state     <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= S_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          S_BREAK: begin
            // A held-low line stays here, so it can never look like a new
            // start bit.
            if (rx) begin
              state <= S_IDLE;
            end
          end

          default: begin
            state    <= S_IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Busy whenever a frame or break is in progress.
  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_ua_receiver.sv
// tb_ua_receiver: scoreboard bench for ua_receiver.
// Stimulus pushes the expected outcome of each frame, decided from the
// frame's own bits, into a queue. A monitor pops one entry on every
// dout_rdy or frame_err strobe and compares.
module tb_ua_receiver;

  localparam int unsigned OS = 16;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       ser_in;
  logic [7:0] dout_byte;
  logic       dout_rdy;
  logic       frame_err;
  logic       busy;

  exp_t       sb[$];
  logic [7:0] model_last;
  int         n_checks;
  int         n_fail;
  int         en_period;
  int         en_cnt;

  ua_receiver #(.OVERSAMPLE(OS)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .ser_in   (ser_in),
    .dout_byte(dout_byte),
    .dout_rdy (dout_rdy),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  // Oversample tick: high one clk in every en_period clks.
  initial begin
    en_cnt = 0;
    enable = 1'b1;
    forever begin
      @(negedge clk);
      if (en_cnt + 1 >= en_period) en_cnt = 0;
      else en_cnt++;
      enable = (en_cnt == 0);
    end
  end

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_last = 8'h00;
      end else if (dout_rdy || frame_err) begin
        check("strobe_mutex", {31'd0, dout_rdy & frame_err}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", {30'd0, dout_rdy, frame_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
          if (e.err) begin
            check("byte_held_on_ferr", {24'd0, dout_byte}, {24'd0, model_last});
          end else begin
            check("dout_byte", {24'd0, dout_byte}, {24'd0, e.data});
            model_last = e.data;
          end
        end
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic send_bit(input logic b);
    ser_in = b;
    repeat (OS * en_period) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    exp_t e;
    e.err  = ~stop_ok;
    e.data = b;
    sb.push_back(e);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int          n;
    logic [7:0]  b;
    logic        bad;
    logic [7:0]  c3;
    n_checks   = 0;
    n_fail     = 0;
    en_period  = 1;
    model_last = 8'h00;
    ser_in     = 1'b1;
    rst        = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);

    check("reset_dout_byte", {24'd0, dout_byte}, 32'd0);
    check("reset_dout_rdy", {31'd0, dout_rdy}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Good byte with tick every clk, plus start-edge-to-ready latency.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        n = 0;
        while (!dout_rdy && n < 400) begin
          @(negedge clk);
          n++;
        end
        n_checks++;
        if (n < 153 || n > 155) begin
          n_fail++;
          $display("FAIL latency_a5: got %0d clk expected 153..155", n);
        end
      end
    join
    wait_clk(OS);

    // Glitch shorter than half a bit is rejected.
    ser_in = 1'b0;
    wait_clk(4);
    ser_in = 1'b1;
    wait_clk(40);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_byte", {24'd0, dout_byte}, 32'h0000_00A5);

    // Framing error, line held low, then release and a good byte.
    send_frame(8'h3C, 1'b0);
    wait_clk(20);
    check("break_busy", {31'd0, busy}, 32'd1);
    wait_clk(20);
    check("break_byte", {24'd0, dout_byte}, 32'h0000_00A5);
    ser_in = 1'b1;
    wait_clk(OS);
    check("break_release_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1);
    wait_clk(OS);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clk(OS);

    // Gated tick: one enable in three clocks.
    en_period = 3;
    wait_clk(3);
    send_frame(8'h81, 1'b1);
    wait_clk(OS * 3);
    check("gated_byte", {24'd0, dout_byte}, 32'h0000_0081);

    // Reset in the middle of data bit 4 of 0xC3; nothing may come out.
    c3 = 8'hC3;
    send_bit(1'b0);
    for (int unsigned i = 0; i < 4; i++) send_bit(c3[i]);
    ser_in = c3[4];
    wait_clk(OS * en_period / 2);
    rst    = 1'b1;
    ser_in = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    check("midreset_dout_byte", {24'd0, dout_byte}, 32'd0);
    check("midreset_dout_rdy", {31'd0, dout_rdy}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    wait_clk(OS * en_period);
    send_frame(8'h11, 1'b1);
    wait_clk(OS * en_period);
    check("post_reset_byte", {24'd0, dout_byte}, 32'h0000_0011);

    // Random bytes, tick rates, gaps and occasional framing errors.
    for (int unsigned k = 0; k < 24; k++) begin
      en_period = $urandom_range(1, 3);
      b         = 8'($urandom);
      bad       = ($urandom_range(0, 7) == 0);
      send_frame(b, ~bad);
      if (bad) begin
        wait_clk($urandom_range(0, 40));
        ser_in = 1'b1;
        wait_clk(2 * OS * en_period);
      end else if ($urandom_range(0, 1) == 1) begin
        wait_clk($urandom_range(1, 40));
      end
    end

    // Drain: every expected strobe must have been seen.
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_scoreboard", sb.size(), 32'd0);
    check("drain_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ua_receiver.md
# ua_receiver

Serial-to-parallel UART receive stage, the counterpart of the UART transmitter on the far end of the serial link. It samples `ser_in` on an oversampled tick, detects and validates the start bit, and shifts in 8 data bits LSB first. It checks the stop bit and presents each good byte with a one-clock ready strobe. The output format (`dout_byte` plus `dout_rdy` pulse) matches the transmitter's `din_byte`/`din_rdy` input, so the two can be looped back directly.

## Interface
- `OVERSAMPLE`, 16: `enable` ticks per bit period; power of two, 4..16.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `enable`  input  1  oversample tick, OVERSAMPLE per bit; may be held high (tick every clk).
- `ser_in`  input  1  asynchronous serial line; idle high.
- `dout_byte`  output  8  last correctly framed byte.
- `dout_rdy`  output  1  one-clk pulse when `dout_byte` is updated.
- `frame_err`  output  1  one-clk pulse when the stop bit samples low.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- Input synchronizer: 2 flops on `ser_in`, reset to 1; `rx` is the second flop. All decisions use `rx`.
- `tick_cnt` is log2(OVERSAMPLE) bits wide and `bit_cnt` is 3 bits wide. Both advance only on clocks where `enable`=1.
- Shift register `shreg[7:0]`: on each data sample, `shreg <= {rx, shreg[7:1]}` (LSB arrives first).
- FSM states and transitions (evaluated only when `enable`=1):
  - IDLE: if `rx`=0, go to START with `tick_cnt`=0.
  - START: increment `tick_cnt`. When `tick_cnt`==OVERSAMPLE/2-1 (mid start bit):
    - if `rx`=0, go to DATA with `tick_cnt`=0 and `bit_cnt`=0;
    - else it is a false start; go to IDLE with no output.
  - DATA: increment `tick_cnt`. When `tick_cnt`==OVERSAMPLE-1 (mid-bit): shift `rx` in and set `tick_cnt`=0. If `bit_cnt`==7, go to STOP; else increment `bit_cnt`.
  - STOP: increment `tick_cnt`. When `tick_cnt`==OVERSAMPLE-1:
    - if `rx`=1: `dout_byte` <= `shreg`, pulse `dout_rdy`, go to IDLE;
    - if `rx`=0: pulse `frame_err`, leave `dout_byte` unchanged, go to BREAK.
  - BREAK: stay until `rx`=1 on a tick, then go to IDLE. A held-low line never produces a spurious frame.
- `dout_byte` holds its value until the next good frame.
- Counters cannot wrap in normal use; each state resets `tick_cnt` on exit.

## Timing
- Reset values: `dout_byte`=8'h00, `dout_rdy`=0, `frame_err`=0, `busy`=0, FSM=IDLE, `tick_cnt`=0, `bit_cnt`=0, `shreg`=0, sync flops=1.
- Reset mid-frame aborts immediately: no `dout_rdy`/`frame_err`, FSM returns to IDLE.
- `ser_in` to `rx` latency: 2 clk.
- Sampling points: start bit at tick OVERSAMPLE/2 after detection; each data bit and the stop bit OVERSAMPLE ticks after the previous sample (bit centres).
- `dout_rdy` and `frame_err`:
  - asserted for exactly one clk, on the edge of the enabled clock that samples the stop bit, independent of `enable` width;
  - mutually exclusive.
- With `enable` tied high and OVERSAMPLE=16: `dout_rdy` rises 2 + 8 + 16*9 = 154 clk after the falling start edge on `ser_in`, ±1 for detection alignment.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. The FSM enters IDLE at mid stop bit, leaving half a bit of margin.
- `busy` goes high the clk after start detection and low on the same edge as `dout_rdy`, or on the edge leaving BREAK.

## Test plan
- Good byte, `enable`=1, 16 clk/bit: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> exactly one `dout_rdy` pulse, `dout_byte`=0xA5, `frame_err` never high.
- Glitch rejection: `ser_in` low for 4 clk then high -> FSM returns to IDLE, no `dout_rdy`, `dout_byte` unchanged.
- Framing error: send 0x3C with the stop bit low, hold low for 40 clk, release, then send 0x5A -> one `frame_err` pulse, no `dout_rdy` for 0x3C, FSM in BREAK until release, then `dout_rdy` with 0x5A.
- Back-to-back: 0x00 then 0xFF with no idle gap -> two `dout_rdy` pulses, values 0x00 then 0xFF.
- Gated tick: `enable` high 1 clk in 3, OVERSAMPLE=16, send 0x81 -> `dout_byte`=0x81, `dout_rdy` one clk wide.
- Reset mid-frame: assert `rst` during data bit 4 of 0xC3, release, then send 0x11 -> no output for 0xC3, outputs at reset values, then `dout_byte`=0x11.
